// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x (OVERSAMPLE) baud tick; samples each bit at its midpoint,
// reports the received word with a one-clock valid strobe or a one-clock framing-error strobe.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bau_tick_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   output logic                 frame_err_o,
   output logic                 busy_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_nxt;
   logic [TW-1:0]        tcnt, tcnt_nxt;
   logic [BW-1:0]        bcnt, bcnt_nxt;
   logic                 rx_meta, rx_s;
   logic                 rx_prev, rx_prev_nxt;
   logic [DATA_BITS-1:0] shreg;
   logic                 shift_en, load_data, valid_nxt, ferr_nxt;

   // Two-flop synchronizer; idles high so reset never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         tcnt        <= '0;
         bcnt        <= '0;
         rx_prev     <= 1'b1;
         rx_data_o   <= '0;
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         state       <= state_nxt;
         tcnt        <= tcnt_nxt;
         bcnt        <= bcnt_nxt;
         rx_prev     <= rx_prev_nxt;
         rx_valid_o  <= valid_nxt;
         frame_err_o <= ferr_nxt;
         if (load_data)
            rx_data_o <= shreg;
      end
   end

   // LSB arrives first, so shifting in at the MSB leaves it at bit 0 after the last data bit.
   always_ff @(posedge clk) begin
      if (shift_en)
         shreg <= {rx_s, shreg[DATA_BITS-1:1]};
   end

   always_comb begin
      state_nxt   = state;
      tcnt_nxt    = tcnt;
      bcnt_nxt    = bcnt;
      rx_prev_nxt = rx_prev;
      shift_en    = 1'b0;
      load_data   = 1'b0;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      if (bau_tick_i) begin
         rx_prev_nxt = rx_s;
         case (state)
            // Start needs a sampled 1->0 edge, so a line held low after a break never retriggers.
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  state_nxt = START;
                  tcnt_nxt  = '0;
               end
            end
            START: begin
               if (tcnt == T_MID) begin
                  tcnt_nxt = '0;
                  if (!rx_s) begin
                     state_nxt = DATA;
                     bcnt_nxt  = '0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            DATA: begin
               if (tcnt == T_END) begin
                  tcnt_nxt = '0;
                  shift_en = 1'b1;
                  if (bcnt == B_LAST)
                     state_nxt = STOP;
                  else
                     bcnt_nxt = bcnt + 1'b1;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            STOP: begin
               // Leaving at mid stop bit gives half a bit of margin for a back-to-back start.
               if (tcnt == T_END) begin
                  tcnt_nxt  = '0;
                  load_data = 1'b1;
                  valid_nxt = rx_s;
                  ferr_nxt  = !rx_s;
                  state_nxt = IDLE;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy_o = (state != IDLE);

endmodule
